// File: rtl/bin2bcd_display_pkg.sv
// Shared definitions for the binary-to-BCD display feeder.
// State encoding, digit width and the digit-count helper.
package bin2bcd_display_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_PUBLISH
    } state_t;

    // Smallest digit count d with 10^d > 2^w.
    function automatic int min_digits(input int w);
        logic [127:0] lim;
        logic [127:0] p;
        int d;
        lim = 128'd1 << w;
        p = 128'd1;
        d = 0;
        for (int i = 0; i < 40; i++) begin
            if (p <= lim) begin
                p = p * 128'd10;
                d = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_display_add3.sv
// One BCD digit correction step of the shift-add-3 conversion.
// Adds 3 to a digit of 5 or more so the next shift carries correctly.
module bcd_add3_slice
    import bin2bcd_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);

    // Correct the digit before it is doubled by the shift.
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_display.sv
// Captures a binary value and presents it as BCD or hex digits
// with a leading-zero blank mask for the seven-segment decoders.
module bin2bcd_display
    import bin2bcd_display_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [DATA_W-1:0]         value_i,
    input  logic                      hex_mode_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [DIGIT_W*DIGITS-1:0] digits_o,
    output logic [DIGITS-1:0]         blank_o
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIGITS-1:0] RST_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};

    if ((DIGITS < min_digits(DATA_W)) || (ACC_W < DATA_W)) begin : g_bad_param
        $error("bin2bcd_display: DIGITS too small for DATA_W");
    end

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    adj;
    logic [CNT_W-1:0]    cnt;
    logic                hex_q;
    logic [ACC_W-1:0]    nxt_digits;
    logic [DIGITS-1:0]   nxt_blank;
    logic                zero_run;

    for (genvar g = 0; g < DIGITS; g++) begin : g_slice
        bcd_add3_slice u_slice (
            .d (acc[g*DIGIT_W +: DIGIT_W]),
            .q (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Select the value to publish and derive its leading-zero mask.
    always_comb begin
        nxt_digits = hex_q ? ACC_W'(shreg) : acc;
        nxt_blank = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (nxt_digits[i*DIGIT_W +: DIGIT_W] == '0);
            nxt_blank[i] = zero_run;
        end
    end

    // Control FSM with the conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            hex_q    <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            digits_o <= '0;
            blank_o  <= RST_BLANK;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load_i) begin
                        shreg  <= value_i;
                        hex_q  <= hex_mode_i;
                        acc    <= '0;
                        cnt    <= CNT_W'(DATA_W);
                        busy_o <= 1'b1;
                        state  <= hex_mode_i ? ST_PUBLISH : ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    acc   <= {adj[ACC_W-2:0], shreg[DATA_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    digits_o <= nxt_digits;
                    blank_o  <= nxt_blank;
                    done_o   <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench for bin2bcd_display.
// Reference digits come from plain division by 10 or 16.
module tb_bin2bcd_display;

    localparam int DW = 16;
    localparam int DG = 6;

    typedef struct {
        logic [4*DG-1:0] d;
        logic [DG-1:0]   b;
        int              acc_edge;
        int              done_edge;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              load_i;
    logic [DW-1:0]     value_i;
    logic              hex_mode_i;
    logic              busy_o;
    logic              done_o;
    logic [4*DG-1:0]   digits_o;
    logic [DG-1:0]     blank_o;

    exp_t q[$];
    int edge_n = 0;
    int free_edge = 0;
    int total = 0;
    int bad = 0;
    logic [4*DG-1:0] last_d;
    logic [DG-1:0]   last_b;

    bin2bcd_display #(.DATA_W(DW), .DIGITS(DG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_i),
        .value_i    (value_i),
        .hex_mode_i (hex_mode_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .digits_o   (digits_o),
        .blank_o    (blank_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s edge=%0d got=%h want=%h", name, edge_n, act, req);
        end
    endtask

    function automatic void ref_model(input int unsigned v, input bit hx,
                                      output logic [4*DG-1:0] d,
                                      output logic [DG-1:0] b);
        int unsigned x;
        int unsigned base;
        bit lead;
        x = v;
        base = hx ? 16 : 10;
        d = '0;
        for (int i = 0; i < DG; i++) begin
            d[i*4 +: 4] = 4'(x % base);
            x = x / base;
        end
        b = '0;
        lead = 1'b1;
        for (int i = DG - 1; i >= 1; i--) begin
            lead = lead && (d[i*4 +: 4] == 4'd0);
            b[i] = lead;
        end
    endfunction

    task automatic step(input bit ld, input int unsigned v, input bit hx,
                        input bit fix, input logic [4*DG-1:0] fd,
                        input logic [DG-1:0] fb);
        exp_t e;
        int a;
        load_i = ld;
        value_i = DW'(v);
        hex_mode_i = hx;
        a = edge_n + 1;
        if (ld && a >= free_edge) begin
            if (fix) begin
                e.d = fd;
                e.b = fb;
            end else begin
                ref_model(v & 32'hFFFF, hx, e.d, e.b);
            end
            e.acc_edge = a;
            e.done_edge = a + (hx ? 1 : DW + 1);
            free_edge = e.done_edge + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        load_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops expectations on done_o, checks busy and output hold.
    initial begin
        exp_t e;
        bit exp_busy;
        last_d = '0;
        last_b = 6'b111110;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                last_d = '0;
                last_b = 6'b111110;
                chk("rst_busy", 32'(busy_o), 32'd0);
                chk("rst_done", 32'(done_o), 32'd0);
                chk("rst_digits", 32'(digits_o), 32'd0);
                chk("rst_blank", 32'(blank_o), 32'b111110);
            end else begin
                exp_busy = 1'b0;
                if (q.size() > 0) begin
                    exp_busy = (edge_n >= q[0].acc_edge) &&
                               (edge_n < q[0].done_edge);
                end
                chk("busy", 32'(busy_o), 32'(exp_busy));
                if (done_o) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("done_edge", 32'(edge_n), 32'(e.done_edge));
                        chk("digits", 32'(digits_o), 32'(e.d));
                        chk("blank", 32'(blank_o), 32'(e.b));
                    end
                    last_d = digits_o;
                    last_b = blank_o;
                end else begin
                    chk("hold_digits", 32'(digits_o), 32'(last_d));
                    chk("hold_blank", 32'(blank_o), 32'(last_b));
                end
            end
        end
    end

    // Stimulus: directed plan items, held load, then random traffic.
    initial begin
        int budget;
        rst_n = 1'b0;
        load_i = 1'b0;
        value_i = '0;
        hex_mode_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        free_edge = edge_n + 1;

        step(1, 1234, 0, 1, 24'h001234, 6'b110000);
        idle(20);
        step(1, 0, 0, 1, 24'h000000, 6'b111110);
        idle(20);
        step(1, 65535, 0, 1, 24'h065535, 6'b100000);
        idle(20);
        step(1, 16'hBEEF, 1, 1, 24'h00BEEF, 6'b110000);
        idle(3);
        step(1, 0, 1, 1, 24'h000000, 6'b111110);
        idle(3);

        step(1, 1234, 0, 1, 24'h001234, 6'b110000);
        idle(4);
        step(1, 9999, 0, 1, 24'h009999, 6'b110000);
        idle(12);
        step(1, 9999, 0, 1, 24'h009999, 6'b110000);
        idle(20);

        step(1, 4321, 0, 1, 24'h004321, 6'b110000);
        idle(7);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        free_edge = edge_n + 1;
        step(1, 4321, 0, 1, 24'h004321, 6'b110000);
        idle(20);

        repeat (20) step(1, $urandom, 1, 0, '0, '0);
        repeat (40) step(1, $urandom, 0, 0, '0, '0);
        idle(20);

        repeat (120) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom,
                 1'($urandom_range(0, 1)), 0, '0, '0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 20));
        end

        budget = 0;
        while (q.size() > 0 && budget < 200) begin
            idle(1);
            budget++;
        end
        if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
